// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------
// if_fetch
//
// Instruction-fetch stage. Holds the program counter and assembles each
// 32-bit instruction from four little-endian byte reads over the shared
// 8-bit memory port. Memory returns a byte one cycle after its address.
// The stage asks the pipeline to stall until the instruction is complete.
// It also handles branch redirects from EX and the loss of the memory port
// to the MEM stage.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous, active-high reset
//   stall[5:0]     pipeline stall vector; bit 0 holds the PC stage
//   branch_flag    one-cycle redirect request from EX
//   branch_target  redirect address (low two bits ignored)
//   mem_grant      memory port granted to IF this cycle
//   mem_din        byte returned by memory, one cycle after its address
//   mem_req        IF issues a byte read this cycle
//   mem_addr       byte address of the read
//   if_pc          PC of the instruction on if_inst
//   if_inst        assembled instruction, NOP_INST while not valid
//   inst_valid     if_inst holds a complete instruction
//   stallreq_if    stall request, the inverse of inst_valid
// ---------------------------------------------------------------------------
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        branch_flag,
  input  logic [31:0] branch_target,
  input  logic        mem_grant,
  input  logic [7:0]  mem_din,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        inst_valid,
  output logic        stallreq_if
);

  typedef enum logic {
    FETCH,
    DONE
  } fetchState_t;

  fetchState_t r_state;
  fetchState_t w_nextState;

  logic [31:0] r_pc;
  logic [2:0]  r_issueCnt;
  logic [2:0]  r_recvCnt;
  logic        r_pend;
  logic [31:0] r_buf;

  logic [31:0] w_nextPc;
  logic [2:0]  w_nextIssueCnt;
  logic [2:0]  w_nextRecvCnt;
  logic        w_nextPend;
  logic [31:0] w_nextBuf;
  logic        w_issue;
  logic [31:0] w_issueAddr;

  // Only bit 0 of the stall vector and the word-aligned part of the branch
  // target matter to this stage.
  logic w_unusedBits;
  assign w_unusedBits = ^{stall[5:1], branch_target[1:0]};

  // A byte read goes out whenever fetching, bytes remain to be issued and
  // the port is ours this cycle. Reset forces the port quiet immediately.
  assign w_issue     = (r_state == FETCH) && (r_issueCnt < 3'd4) && mem_grant;
  assign w_issueAddr = r_pc + {29'b0, r_issueCnt};

  assign mem_req     = w_issue && !rst;
  assign mem_addr    = rst ? 32'h0 : w_issueAddr;

  assign inst_valid  = (r_state == DONE);
  assign stallreq_if = ~inst_valid;
  assign if_inst     = inst_valid ? r_buf : NOP_INST;
  assign if_pc       = r_pc;

  // State and datapath registers. All next values come from the
  // combinational block below; reset returns to a clean fetch at RESET_PC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= FETCH;
      r_pc       <= RESET_PC;
      r_issueCnt <= 3'd0;
      r_recvCnt  <= 3'd0;
      r_pend     <= 1'b0;
      r_buf      <= 32'h0;
    end else begin
      r_state    <= w_nextState;
      r_pc       <= w_nextPc;
      r_issueCnt <= w_nextIssueCnt;
      r_recvCnt  <= w_nextRecvCnt;
      r_pend     <= w_nextPend;
      r_buf      <= w_nextBuf;
    end
  end

  // Next-state logic. Normal issue/capture in FETCH, accept-or-hold in
  // DONE, then a branch overrides everything: it restarts the fetch at the
  // aligned target and drops any byte still in flight.
  always_comb begin
    w_nextState    = r_state;
    w_nextPc       = r_pc;
    w_nextIssueCnt = r_issueCnt;
    w_nextRecvCnt  = r_recvCnt;
    w_nextPend     = 1'b0;
    w_nextBuf      = r_buf;

    case (r_state)
      FETCH: begin
        if (w_issue) begin
          w_nextIssueCnt = r_issueCnt + 3'd1;
          w_nextPend     = 1'b1;
        end
        // The byte in flight is captured even across a grant gap.
        if (r_pend) begin
          case (r_recvCnt[1:0])
            2'd0: w_nextBuf[7:0]   = mem_din;
            2'd1: w_nextBuf[15:8]  = mem_din;
            2'd2: w_nextBuf[23:16] = mem_din;
            default: w_nextBuf[31:24] = mem_din;
          endcase
          w_nextRecvCnt = r_recvCnt + 3'd1;
          if (r_recvCnt == 3'd3) begin
            w_nextState = DONE;
          end
        end
      end
      DONE: begin
        if (!stall[0]) begin
          w_nextPc       = r_pc + 32'd4;
          w_nextIssueCnt = 3'd0;
          w_nextRecvCnt  = 3'd0;
          w_nextState    = FETCH;
        end
      end
      default: begin
        w_nextState = FETCH;
      end
    endcase

    if (branch_flag) begin
      w_nextPc       = {branch_target[31:2], 2'b00};
      w_nextIssueCnt = 3'd0;
      w_nextRecvCnt  = 3'd0;
      w_nextPend     = 1'b0;
      w_nextState    = FETCH;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// ---------------------------------------------------------------------------
// tb_if_fetch
//
// Directed bench for if_fetch. A small byte memory answers every address one
// cycle later. Inputs change 1 time unit after each rising edge, and outputs
// are sampled 1 time unit after that.
// ---------------------------------------------------------------------------
module tb_if_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        mem_grant;
  logic [7:0]  mem_din;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        inst_valid;
  logic        stallreq_if;

  logic [7:0]  mem [0:511];
  int          testCount;
  int          failCount;

  if_fetch dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_flag   (branch_flag),
    .branch_target (branch_target),
    .mem_grant     (mem_grant),
    .mem_din       (mem_din),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .if_pc         (if_pc),
    .if_inst       (if_inst),
    .inst_valid    (inst_valid),
    .stallreq_if   (stallreq_if)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Byte memory with one cycle of read latency.
  always @(posedge clk) begin
    mem_din <= mem[mem_addr[8:0]];
  end

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the per-cycle inputs, then let combinational outputs settle.
  task automatic applyStimulus(input logic grant, input logic stallPc,
                               input logic br, input logic [31:0] target);
    mem_grant     = grant;
    stall         = {5'b0, stallPc};
    branch_flag   = br;
    branch_target = target;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 8'(i) ^ 8'hA5;
    // 0x00000513 at 0x0, 0x12345678 at 0x4, 0x003412B7 at 0x100,
    // 0x00210133 at 0x40.
    mem[0]     = 8'h13; mem[1]     = 8'h05; mem[2]     = 8'h00; mem[3]     = 8'h00;
    mem[4]     = 8'h78; mem[5]     = 8'h56; mem[6]     = 8'h34; mem[7]     = 8'h12;
    mem[9'h100] = 8'hB7; mem[9'h101] = 8'h12; mem[9'h102] = 8'h34; mem[9'h103] = 8'h00;
    mem[9'h040] = 8'h33; mem[9'h041] = 8'h01; mem[9'h042] = 8'h21; mem[9'h043] = 8'h00;
    testCount = 0;
    failCount = 0;

    // Reset with grant already offered: the port must stay quiet.
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("rst_valid",    {31'b0, inst_valid},  32'h0);
    checkOutput("rst_inst",     if_inst,              NOP);
    checkOutput("rst_pc",       if_pc,                32'h0);
    checkOutput("rst_stallreq", {31'b0, stallreq_if}, 32'h1);
    checkOutput("rst_memreq",   {31'b0, mem_req},     32'h0);

    // Start a fetch, then reset it with issue_cnt = 2.
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("mid_addr0", mem_addr, 32'h0);
    tick();
    checkOutput("mid_addr1", mem_addr, 32'h1);
    tick();
    checkOutput("mid_addr2", mem_addr, 32'h2);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_valid",  {31'b0, inst_valid}, 32'h0);
    checkOutput("mid_rst_inst",   if_inst,             NOP);
    checkOutput("mid_rst_pc",     if_pc,               32'h0);
    checkOutput("mid_rst_memreq", {31'b0, mem_req},    32'h0);
    checkOutput("mid_rst_addr",   mem_addr,            32'h0);
    tick();
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);

    // Basic fetch with continuous grant: addresses 0..3 in cycles n..n+3.
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("basic_req%0d", k),  {31'b0, mem_req},    32'h1);
      checkOutput($sformatf("basic_addr%0d", k), mem_addr,            32'(k));
      checkOutput($sformatf("basic_nv%0d", k),   {31'b0, inst_valid}, 32'h0);
      tick();
    end
    checkOutput("basic_n4_valid", {31'b0, inst_valid}, 32'h0);
    tick();

    // Cycle n+5: instruction complete. Hold it with stall[0] for 3 cycles.
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("hold_valid%0d", k),    {31'b0, inst_valid},  32'h1);
      checkOutput($sformatf("hold_inst%0d", k),     if_inst,              32'h0000_0513);
      checkOutput($sformatf("hold_pc%0d", k),       if_pc,                32'h0);
      checkOutput($sformatf("hold_memreq%0d", k),   {31'b0, mem_req},     32'h0);
      checkOutput($sformatf("hold_stallreq%0d", k), {31'b0, stallreq_if}, 32'h0);
      tick();
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("release_valid", {31'b0, inst_valid}, 32'h1);
    checkOutput("release_inst",  if_inst,             32'h0000_0513);
    tick();

    // Accepted: the next instruction starts at address 4.
    checkOutput("next_pc",    if_pc,               32'h4);
    checkOutput("next_addr",  mem_addr,            32'h4);
    checkOutput("next_req",   {31'b0, mem_req},    32'h1);
    checkOutput("next_valid", {31'b0, inst_valid}, 32'h0);
    checkOutput("next_inst",  if_inst,             NOP);
    tick();

    // Grant gap of 2 cycles right after byte 1 is issued.
    checkOutput("gap_addr5", mem_addr, 32'h5);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("gap_req_a", {31'b0, mem_req}, 32'h0);
    tick();
    checkOutput("gap_req_b", {31'b0, mem_req}, 32'h0);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("gap_addr6", mem_addr, 32'h6);
    tick();
    checkOutput("gap_addr7", mem_addr, 32'h7);
    tick();
    checkOutput("gap_m6_valid", {31'b0, inst_valid}, 32'h0);
    tick();
    checkOutput("gap_valid", {31'b0, inst_valid}, 32'h1);
    checkOutput("gap_inst",  if_inst,             32'h1234_5678);
    checkOutput("gap_pc",    if_pc,               32'h4);
    tick();

    // Accepted; fetch at 8. Branch to 0x103 once issue_cnt = 2.
    checkOutput("br_addr8", mem_addr, 32'h8);
    tick();
    checkOutput("br_addr9", mem_addr, 32'h9);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_0103);
    checkOutput("br_cycle_req",  {31'b0, mem_req}, 32'h1);
    checkOutput("br_cycle_addr", mem_addr,         32'hA);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("br_pc",    if_pc,               32'h100);
    checkOutput("br_valid", {31'b0, inst_valid}, 32'h0);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("br_addr%0d", k), mem_addr, 32'h100 + 32'(k));
      tick();
    end
    tick();
    checkOutput("br_done_valid", {31'b0, inst_valid}, 32'h1);
    checkOutput("br_done_inst",  if_inst,             32'h0034_12B7);
    checkOutput("br_done_pc",    if_pc,               32'h100);

    // Branch and accept on the same edge: the branch target wins.
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_0040);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("sim_pc",    if_pc,               32'h40);
    checkOutput("sim_addr",  mem_addr,            32'h40);
    checkOutput("sim_valid", {31'b0, inst_valid}, 32'h0);
    repeat (5) tick();
    checkOutput("sim_done_valid", {31'b0, inst_valid}, 32'h1);
    checkOutput("sim_done_inst",  if_inst,             32'h0021_0133);
    checkOutput("sim_done_pc",    if_pc,               32'h40);

    // Branch while stalled in DONE is still taken.
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0008);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("stbr_pc",    if_pc,               32'h8);
    checkOutput("stbr_addr",  mem_addr,            32'h8);
    checkOutput("stbr_valid", {31'b0, inst_valid}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage. Holds the PC and fetches each 32-bit instruction as four little-endian bytes over the shared 8-bit memory port.
- Presents if_pc/if_inst to the IF/ID pipeline register.
- Raises a stall request until the instruction is complete.
- Handles branch redirects from EX and loss of the memory port to the MEM stage, which has priority.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- NOP_INST, 32'h00000013, value driven on if_inst when no instruction is valid.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- stall  in  6  pipeline stall vector; bit 0 = PC stage (1 = hold).
- branch_flag  in  1  one-cycle redirect request from EX.
- branch_target  in  32  redirect address; bits [1:0] forced to 0 internally.
- mem_grant  in  1  port granted to IF this cycle.
- mem_din  in  8  byte returned by memory, valid one cycle after its address.
- mem_req  out  1  IF issues a byte read this cycle.
- mem_addr  out  32  byte address of the read.
- if_pc  out  32  PC of the instruction on if_inst.
- if_inst  out  32  assembled instruction; NOP_INST when inst_valid = 0.
- inst_valid  out  1  if_inst holds a complete instruction.
- stallreq_if  out  1  equals ~inst_valid.

Behaviour:
- Reset (async, mid-fetch included): pc = RESET_PC, issue_cnt = 0, recv_cnt = 0, pend = 0, byte buffer = 0, inst_valid = 0, mem_req = 0, mem_addr = 0, if_pc = RESET_PC, if_inst = NOP_INST, stallreq_if = 1.
- State machine states:
  - FETCH: issuing and receiving bytes.
  - DONE: inst_valid = 1; hold until accepted.
- Issue (FETCH, issue_cnt < 4):
  - mem_req = mem_grant; mem_addr = pc + issue_cnt (32-bit wrap).
  - On a granted edge: issue_cnt++ and pend = 1, otherwise pend = 0.
  - When no grant, mem_req = 0 and nothing is issued; mem_addr is don't-care.
- Receive: on each edge with pend = 1, mem_din is written into byte lane recv_cnt of the buffer and recv_cnt++.
  - Lanes: lane 0 = bits[7:0], lane 3 = bits[31:24].
  - A grant gap only delays issue. The byte already in flight is still captured.
- Latency: with continuous grant, bytes are issued in cycles n..n+3 and captured at the edges ending n+1..n+4. inst_valid rises in cycle n+5 (5 cycles after issue start).
- Completion: the edge that captures byte 3 moves the block to DONE. inst_valid = 1, if_inst = buffer, if_pc = pc.
- Accept: in DONE with stall[0] = 0 and branch_flag = 0:
  - next edge: pc <= pc + 4, counters cleared, return to FETCH, inst_valid = 0.
  - The first byte of the next instruction can be issued in the following cycle, so back-to-back instructions take 6 cycles each.
- Hold: in DONE with stall[0] = 1, all outputs are held, mem_req = 0, no reads are issued.
- Branch: branch_flag = 1 on an edge, in any state, does all of the following:
  - pc <= {branch_target[31:2], 2'b00}
  - issue_cnt, recv_cnt, pend <= 0
  - return to FETCH, inst_valid <= 0
  - The in-flight byte (pend) is discarded.
  - mem_req in the branch cycle is still driven by the normal issue rule; any returned byte is ignored.
- Priority, highest first: rst, branch_flag, accept, capture/issue.
  - branch_flag and accept on the same edge: branch wins; pc = target, not pc + 4.
  - branch_flag with stall[0] = 1: branch still taken. Stall gates only sequential advance.
- if_pc and if_inst change only at state changes. They are stable throughout DONE.

Test Plan:
- Reset: assert rst mid-fetch (issue_cnt = 2) -> immediately inst_valid = 0, if_inst = 0x00000013, if_pc = 0. First mem_addr after release = 0x0.
- Basic fetch: grant = 1, bytes 0x13,0x05,0x00,0x00 at addrs 0..3 -> mem_addr 0,1,2,3 on consecutive cycles. inst_valid in cycle 5, if_inst = 0x00000513, if_pc = 0. Next fetch issues at addr 4.
- Grant gap: drop mem_grant for 2 cycles after byte 1 issued -> byte 1 still captured, mem_req = 0 during gap, inst_valid delayed by exactly 2 cycles, value correct.
- Stall: stall[0] = 1 for 3 cycles while DONE -> if_pc/if_inst stable, mem_req = 0. Release -> pc = 4, fetch resumes.
- Branch mid-fetch: branch_flag with target 0x103 while issue_cnt = 2 -> pending byte discarded, next mem_addr = 0x100, assembled if_pc = 0x100.
- Simultaneous: branch_flag and accept (DONE, stall[0] = 0) on the same edge, target 0x40 -> pc = 0x40, not pc + 4.
